// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory unit: access sizes, fault codes
// and the request FSM states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline MEM stage (master) and dmem_unit (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [1:0]  resp_fault_code;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code
  );
endinterface

// File: rtl/dmem_byte_lane.sv
// Big-endian lane steering: byte enables and positioned store data, plus load
// lane extraction with sign or zero extension.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant lane, so the shift is (3 - offset) bytes.
  assign byte_lane = 8'(rword_i >> {~offset_i, 3'b000});
  assign half_lane = 16'(rword_i >> {~offset_i[1], 4'b0000});

  always_comb begin
    be_o    = 4'b0000;
    wword_o = 32'h0;
    rdata_o = 32'h0;
    unique case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b1000 >> offset_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = is_unsigned_i ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        be_o    = offset_i[1] ? 4'b0011 : 4'b1100;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = is_unsigned_i ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rword_i;
      end
      default: begin
        be_o    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_unit.sv
// Clocked data memory for the MEM stage: valid/ready requests, programmable wait
// states, byte/half/word access and alignment/range fault reporting.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h7fff0000,
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic    clk,
  input logic    rst_n,
  dmem_if.slave  bus
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] AddrEnd  = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
  localparam bit          ZeroWait = (WAIT_STATES == 0);
  localparam logic [3:0]  WaitInit = ZeroWait ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rdy_en_q;

  logic            wr_q, uns_q;
  logic [1:0]      size_q, off_q, flt_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wdata_q;

  logic        resp_fault_q;
  logic [1:0]  resp_code_q;
  logic [31:0] resp_rdata_q;

  logic            accept, misalign, out_of_range, commit;
  logic [1:0]      in_flt;
  logic [IdxW-1:0] in_idx;

  logic            c_wr, c_uns;
  logic [1:0]      c_size, c_off, c_flt;
  logic [IdxW-1:0] c_idx;
  logic [31:0]     c_wdata;

  logic [3:0]  be;
  logic [31:0] wword, rword, lane_rdata;
  logic [31:0] mem [DEPTH_WORDS];

  assign bus.req_ready       = rdy_en_q && (state_q != StWait);
  assign bus.resp_valid      = (state_q == StResp);
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_fault      = resp_fault_q;
  assign bus.resp_fault_code = resp_code_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign in_idx = IdxW'((bus.req_addr - ADDR_BASE) >> 2);

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = bus.req_addr[0];
      SZ_WORD: misalign = |bus.req_addr[1:0];
      default: misalign = 1'b1;
    endcase
    out_of_range = ({1'b0, bus.req_addr} < {1'b0, ADDR_BASE}) ||
                   ({1'b0, bus.req_addr} >= AddrEnd);
    in_flt = misalign ? FLT_MISALIGN : (out_of_range ? FLT_RANGE : FLT_NONE);
  end

  // With no wait states the access completes on the accept edge itself.
  always_comb begin
    if (ZeroWait) begin
      c_wr    = bus.req_write;
      c_uns   = bus.req_unsigned;
      c_size  = bus.req_size;
      c_off   = bus.req_addr[1:0];
      c_flt   = in_flt;
      c_idx   = in_idx;
      c_wdata = bus.req_wdata;
    end else begin
      c_wr    = wr_q;
      c_uns   = uns_q;
      c_size  = size_q;
      c_off   = off_q;
      c_flt   = flt_q;
      c_idx   = idx_q;
      c_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (accept) begin
          state_d = ZeroWait ? StResp : StWait;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gated by rst_n so a request pending at reset never reaches the array.
  assign commit = (state_d == StResp) && rst_n;
  assign rword  = mem[c_idx];

  dmem_byte_lane u_lane (
    .size_i        (c_size),
    .offset_i      (c_off),
    .is_unsigned_i (c_uns),
    .wdata_i       (c_wdata),
    .rword_i       (rword),
    .be_o          (be),
    .wword_o       (wword),
    .rdata_o       (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      rdy_en_q     <= 1'b0;
      wr_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      flt_q        <= FLT_NONE;
      idx_q        <= '0;
      wdata_q      <= 32'h0;
      resp_fault_q <= 1'b0;
      resp_code_q  <= FLT_NONE;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
      if (accept) begin
        wr_q    <= bus.req_write;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        off_q   <= bus.req_addr[1:0];
        flt_q   <= in_flt;
        idx_q   <= in_idx;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        resp_fault_q <= (c_flt != FLT_NONE);
        resp_code_q  <= c_flt;
        resp_rdata_q <= ((c_flt == FLT_NONE) && !c_wr) ? lane_rdata : 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_wr && (c_flt == FLT_NONE)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[c_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboarded bench for dmem_unit: directed and random traffic against a byte-level
// reference model, plus zero-wait back-to-back and reset-during-wait scenarios.
module tb_dmem_unit;
  import dmem_pkg::*;

  localparam logic [31:0] BASE        = 32'h7fff0000;
  localparam int unsigned DEPTH       = 16384;
  localparam int unsigned SMALL_DEPTH = 64;
  localparam int          WS          = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  code;
    bit          chk;
    int          cyc;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst3_n = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   pulses0  = 0;

  exp_t        q_main[$];
  exp_t        q0[$];
  exp_t        q3[$];
  logic [31:0] mem_m [int unsigned];

  dmem_if mif ();
  dmem_if mif0 ();
  dmem_if mif3 ();

  dmem_unit #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  dmem_unit #(.ADDR_BASE(BASE), .DEPTH_WORDS(SMALL_DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif0)
  );

  dmem_unit #(.ADDR_BASE(BASE), .DEPTH_WORDS(SMALL_DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (mif3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  task automatic check_resp(input string tag, input exp_t e, input logic [31:0] rd,
                            input logic f, input logic [1:0] c, input int want_lat);
    if (e.chk) check({tag, "_rdata"}, rd, e.rdata);
    check({tag, "_fault"}, 32'(f), 32'(e.fault));
    check({tag, "_code"}, 32'(c), 32'(e.code));
    check({tag, "_latency"}, 32'(cyc - e.cyc), 32'(want_lat));
  endtask

  // Byte-addressed reference: mask/shift arithmetic on a word map.
  task automatic ref_model(input bit w, input logic [1:0] sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int unsigned off, nbytes, shift, idx;
    logic [31:0] mask, old, v;
    bit mis, rng;
    off = a % 4;
    mis = (sz == 2'b11) || (sz == 2'b01 && off % 2 != 0) || (sz == 2'b10 && off != 0);
    rng = (a < BASE) || ({1'b0, a} >= {1'b0, BASE} + 33'(4 * DEPTH));
    e.rdata = 32'h0;
    e.fault = mis || rng;
    e.code  = mis ? 2'b01 : (rng ? 2'b10 : 2'b00);
    e.chk   = 1'b1;
    e.cyc   = 0;
    if (e.fault) return;
    idx    = (a - BASE) / 4;
    nbytes = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    shift  = 8 * (4 - nbytes - off);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    old    = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
    if (w) begin
      mem_m[idx] = (old & ~(mask << shift)) | ((wd & mask) << shift);
    end else begin
      e.chk = mem_m.exists(idx);
      v = (old >> shift) & mask;
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      e.rdata = v;
    end
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_k = 1'b0,
                       input logic [31:0] k_rdata = 32'h0, input logic [1:0] k_code = 2'b00);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    mif.req_write    = w;
    mif.req_size     = sz;
    mif.req_unsigned = uns;
    mif.req_addr     = a;
    mif.req_wdata    = wd;
    mif.req_valid    = 1'b1;
    while (mif.req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (mif.req_ready !== 1'b1) begin
      fail_now("main_ready_timeout", "req_ready=0 for 64 cycles, required 1");
      mif.req_valid = 1'b0;
      return;
    end
    ref_model(w, sz, uns, a, wd, e);
    if (use_k) begin
      e.rdata = k_rdata;
      e.fault = (k_code != 2'b00);
      e.code  = k_code;
      e.chk   = 1'b1;
    end
    e.cyc = cyc;
    q_main.push_back(e);
    @(posedge clk);
    #1;
    mif.req_valid = 1'b0;
  endtask

  task automatic issue3(input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input bit expect_resp, input logic [31:0] k_rdata);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    mif3.req_write    = w;
    mif3.req_size     = SZ_WORD;
    mif3.req_unsigned = 1'b0;
    mif3.req_addr     = a;
    mif3.req_wdata    = wd;
    mif3.req_valid    = 1'b1;
    while (mif3.req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (mif3.req_ready !== 1'b1) begin
      fail_now("ws3_ready_timeout", "req_ready=0 for 64 cycles, required 1");
      mif3.req_valid = 1'b0;
      return;
    end
    e.rdata = k_rdata;
    e.fault = 1'b0;
    e.code  = FLT_NONE;
    e.chk   = 1'b1;
    e.cyc   = cyc;
    if (expect_resp) q3.push_back(e);
    @(posedge clk);
    #1;
    mif3.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_main.size() + q0.size() + q3.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queues_drained", 32'(q_main.size() + q0.size() + q3.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mif.resp_valid === 1'b1) begin
        if (q_main.size() == 0) fail_now("main_unexpected_resp", "resp_valid=1, required 0");
        else begin
          e = q_main.pop_front();
          check_resp("main", e, mif.resp_rdata, mif.resp_fault, mif.resp_fault_code, WS + 1);
        end
      end
      if (mif0.resp_valid === 1'b1) begin
        pulses0++;
        if (q0.size() == 0) fail_now("ws0_unexpected_resp", "resp_valid=1, required 0");
        else begin
          e = q0.pop_front();
          check_resp("ws0", e, mif0.resp_rdata, mif0.resp_fault, mif0.resp_fault_code, 1);
        end
      end
      if (mif3.resp_valid === 1'b1) begin
        if (q3.size() == 0) fail_now("ws3_unexpected_resp", "resp_valid=1, required 0");
        else begin
          e = q3.pop_front();
          check_resp("ws3", e, mif3.resp_rdata, mif3.resp_fault, mif3.resp_fault_code, 4);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] last_wd;
    exp_t        e;
    mif.req_valid  = 1'b0; mif.req_write  = 1'b0; mif.req_size  = SZ_WORD;
    mif.req_unsigned = 1'b0; mif.req_addr = BASE; mif.req_wdata = 32'h0;
    mif0.req_valid = 1'b0; mif0.req_write = 1'b0; mif0.req_size = SZ_WORD;
    mif0.req_unsigned = 1'b0; mif0.req_addr = BASE; mif0.req_wdata = 32'h0;
    mif3.req_valid = 1'b0; mif3.req_write = 1'b0; mif3.req_size = SZ_WORD;
    mif3.req_unsigned = 1'b0; mif3.req_addr = BASE; mif3.req_wdata = 32'h0;
    fork
      monitor();
    join_none

    #2;
    check("rst_req_ready", 32'(mif.req_ready), 32'd0);
    check("rst_resp_valid", 32'(mif.resp_valid), 32'd0);
    check("rst_resp_rdata", mif.resp_rdata, 32'h0);
    check("rst_resp_fault", 32'(mif.resp_fault), 32'd0);
    check("rst_resp_code", 32'(mif.resp_fault_code), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_req_ready_held", 32'(mif.req_ready), 32'd0);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    #1;
    check("ready_before_first_clk", 32'(mif.req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_first_clk", 32'(mif.req_ready), 32'd1);

    // Zero the words the random traffic can touch so every load is checkable.
    for (int i = 0; i < 16; i++) issue(1'b1, SZ_WORD, 1'b0, BASE + 32'(4 * i), 32'h0);
    issue(1'b1, SZ_WORD, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0);

    issue(1'b1, SZ_WORD, 1'b0, 32'h7fff0010, 32'hDEADBEEF, 1'b1, 32'h0, FLT_NONE);
    issue(1'b0, SZ_WORD, 1'b0, 32'h7fff0010, 32'h0, 1'b1, 32'hDEADBEEF, FLT_NONE);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h7fff0021, 32'h80, 1'b1, 32'h0, FLT_NONE);
    issue(1'b0, SZ_WORD, 1'b0, 32'h7fff0020, 32'h0, 1'b1, 32'h00800000, FLT_NONE);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h7fff0021, 32'h0, 1'b1, 32'hFFFFFF80, FLT_NONE);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h7fff0021, 32'h0, 1'b1, 32'h00000080, FLT_NONE);
    issue(1'b0, SZ_HALF, 1'b0, 32'h7fff0020, 32'h0, 1'b1, 32'h00000080, FLT_NONE);
    issue(1'b0, SZ_WORD, 1'b0, 32'h7fff0002, 32'h0, 1'b1, 32'h0, FLT_MISALIGN);
    issue(1'b1, SZ_WORD, 1'b0, 32'h7ffeFFFC, 32'hCAFEF00D, 1'b1, 32'h0, FLT_RANGE);
    // 0x7ffeFFFC aliases the last word after index truncation; it must be untouched.
    issue(1'b0, SZ_WORD, 1'b0, 32'h7ffffffc, 32'h0, 1'b1, 32'h0, FLT_NONE);
    issue(1'b0, SZ_HALF, 1'b0, 32'h80000001, 32'h0, 1'b1, 32'h0, FLT_MISALIGN);
    issue(1'b0, 2'b11, 1'b0, 32'h7fff0000, 32'h0, 1'b1, 32'h0, FLT_MISALIGN);

    for (int i = 0; i < 300; i++) begin
      int unsigned pick;
      logic [31:0] a;
      pick = $urandom_range(0, 9);
      if (pick < 8)       a = BASE + 32'($urandom_range(0, 63));
      else if (pick == 8) a = BASE - 32'($urandom_range(1, 16));
      else                a = BASE + 32'(4 * DEPTH) - 32'd4 + 32'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    wait_drain();

    // Zero wait states: valid held high across four alternating sw/lw.
    last_wd = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mif0.req_valid    = 1'b1;
      mif0.req_write    = (i % 2 == 0);
      mif0.req_size     = SZ_WORD;
      mif0.req_unsigned = 1'b0;
      mif0.req_addr     = BASE + 32'h8;
      mif0.req_wdata    = (i == 0) ? 32'h11112222 : 32'hA5C30F96;
      check("ws0_ready", 32'(mif0.req_ready), 32'd1);
      e.rdata = (i % 2 == 0) ? 32'h0 : last_wd;
      e.fault = 1'b0;
      e.code  = FLT_NONE;
      e.chk   = 1'b1;
      e.cyc   = cyc;
      if (i % 2 == 0) last_wd = mif0.req_wdata;
      q0.push_back(e);
      @(posedge clk);
      #1;
    end
    mif0.req_valid = 1'b0;
    wait_drain();
    check("ws0_pulse_count", 32'(pulses0), 32'd4);

    // Three wait states: reset lands in the second wait cycle of a store.
    issue3(1'b1, BASE + 32'h30, 32'h0, 1'b1, 32'h0);
    issue3(1'b1, BASE + 32'h34, 32'hA5A5A5A5, 1'b1, 32'h0);
    issue3(1'b0, BASE + 32'h34, 32'h0, 1'b1, 32'hA5A5A5A5);
    wait_drain();
    issue3(1'b1, BASE + 32'h30, 32'h12345678, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst3_n = 1'b0;
    #1;
    check("ws3_rst_ready", 32'(mif3.req_ready), 32'd0);
    check("ws3_rst_valid", 32'(mif3.resp_valid), 32'd0);
    check("ws3_rst_rdata", mif3.resp_rdata, 32'h0);
    check("ws3_rst_fault", 32'(mif3.resp_fault), 32'd0);
    check("ws3_rst_code", 32'(mif3.resp_fault_code), 32'd0);
    repeat (6) @(negedge clk);
    rst3_n = 1'b1;
    #1;
    check("ws3_ready_before_clk", 32'(mif3.req_ready), 32'd0);
    @(negedge clk);
    check("ws3_ready_after_clk", 32'(mif3.req_ready), 32'd1);
    issue3(1'b0, BASE + 32'h30, 32'h0, 1'b1, 32'h0);
    wait_drain();

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
